issue_scoreboard: RTL
=====================

# issue_scoreboard

Dual-issue in-order issue stage placed directly upstream of the 4-read/2-write register file. Each cycle it takes up to two decoded instructions from the decode queue, checks them against a per-register busy scoreboard and against each other, and issues 0, 1 or 2 instructions in program order. Issued instructions go into an output register that drives the register-file read addresses. Writeback ports clear scoreboard entries.

## Interface
- No parameters; 32 architectural registers, 5-bit addresses, 32-bit PC.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous pipeline flush.
- inN_valid  in  1  slot N (N=1,2) holds a decoded instruction; slot 2 is younger.
- inN_rs1, inN_rs2, inN_rd  in  5 each  slot N register fields.
- inN_rs1_use, inN_rs2_use, inN_wen  in  1 each  slot N reads rs1, reads rs2, writes rd.
- inN_pc  in  32  slot N PC, passed through unchanged.
- inN_accept  out  1  combinational; slot N consumed this cycle.
- iss_ready  in  1  downstream can take the issue register contents.
- issN_valid, issN_rd, issN_wen, issN_pc  out  1/5/1/32  issue register.
- instr1_rs1, instr1_rs2, instr2_rs1, instr2_rs2  out  5 each  registered register-file read addresses.
- write1, rd1, write2, rd2  in  1/5/1/5  writeback ports, shared with the register file.

## Operation
- busy[31:1] is the scoreboard. busy[0] is constant 0.
- clr[r] = (write1 & rd1==r) | (write2 & rd2==r). busy_eff = busy & ~clr, so a same-cycle writeback unblocks.
- adv = iss_ready | ~(iss1_valid | iss2_valid).
- Slot 1 hazard: (rs1_use & busy_eff[rs1]) | (rs2_use & busy_eff[rs2]) | (wen & busy_eff[rd]).
- in1_accept = adv & ~flush & in1_valid & ~hazard1.
- in2_accept = in1_accept & in2_valid & ~hazard2 & ~pair, where:
  - hazard2 is the slot-2 hazard, defined the same way as slot 1.
  - pair = in1_wen & in1_rd!=0 & ((in2_rs1_use & in2_rs1==in1_rd) | (in2_rs2_use & in2_rs2==in1_rd) | (in2_wen & in2_rd==in1_rd)).
- Slot 2 never issues alone; order is preserved.
- On adv & ~flush, the issue register loads:
  - issN_valid = inN_accept, plus the accepted slot fields.
  - instrN_rsX = inN_rsX when rsX_use, else 0.
  - Fields of an unaccepted slot load 0.
- When adv is 0, the issue register holds all values.
- Scoreboard next state: busy[r] = (busy[r] & ~clr[r]) | set[r].
  - set[r] = OR over accepted slots of (wen & rd==r & r!=0).
  - Set has priority over a same-cycle clear.
- Writebacks to rd=0 or to a non-busy register have no effect.
- flush: next cycle all issN_valid=0, all busy=0, and read addresses=0. No accept in the flush cycle; writebacks in that cycle are ignored.

## Timing
- Reset values: busy=0, issN_valid=0, issN_rd=0, issN_wen=0, issN_pc=0, all instrN_rsX=0. inN_accept is 0 while rst_n=0.
- Accept is same-cycle combinational. Issue register outputs are valid the cycle after accept (latency 1).
- A busy set at edge E blocks dependents from the cycle after E. A writeback in cycle C lets a dependent accept in the same cycle C.
- Handshake: the issue register contents transfer when issN_valid & iss_ready. Contents are stable while iss_ready=0.
- Asserting reset mid-operation clears all state immediately. The first accept is possible in the first cycle after deassertion.

## Test plan
- Independent pair: in1 add x3←x1,x2 and in2 add x6←x4,x5, all regs free, iss_ready=1 → both accept. Next cycle iss1_valid=iss2_valid=1, instr1_rs1=1, instr2_rs2=5, busy[3]=busy[6]=1.
- Intra-pair RAW: in1 writes x7, in2 reads x7 → only in1_accept. Next cycle, in2 (now in slot 1) stays blocked until write1 with rd1=7. It accepts in that same writeback cycle.
- WAW and x0: in1 and in2 both write x0 → both issue and no busy set. in1 and in2 both write x9 → slot 1 only.
- Backpressure: iss_ready=0 with iss1_valid=1 → accept=0 and outputs held 5 cycles. Raising iss_ready → new pair accepted the same cycle.
- Set/clear race: busy[4]=1; write2 with rd2=4 in the same cycle that in1 writes x4 → accept, and busy[4]=1 afterwards.
- Flush and reset: flush with busy[10]=1 and valid outputs → next cycle all valids 0, busy=0. Asserting rst_n low mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// Decode-queue, issue-register and writeback signals shared between the issue stage and its neighbours.
interface issue_scoreboard_if;
  logic        flush;
  logic        in1_valid, in2_valid;
  logic [4:0]  in1_rs1, in1_rs2, in1_rd, in2_rs1, in2_rs2, in2_rd;
  logic        in1_rs1_use, in1_rs2_use, in1_wen, in2_rs1_use, in2_rs2_use, in2_wen;
  logic [31:0] in1_pc, in2_pc;
  logic        in1_accept, in2_accept;
  logic        iss_ready;
  logic        iss1_valid, iss2_valid, iss1_wen, iss2_wen;
  logic [4:0]  iss1_rd, iss2_rd;
  logic [31:0] iss1_pc, iss2_pc;
  logic [4:0]  instr1_rs1, instr1_rs2, instr2_rs1, instr2_rs2;
  logic        write1, write2;
  logic [4:0]  rd1, rd2;

  modport master (
    output flush, in1_valid, in2_valid, in1_rs1, in1_rs2, in1_rd, in2_rs1, in2_rs2, in2_rd,
           in1_rs1_use, in1_rs2_use, in1_wen, in2_rs1_use, in2_rs2_use, in2_wen,
           in1_pc, in2_pc, iss_ready, write1, write2, rd1, rd2,
    input  in1_accept, in2_accept, iss1_valid, iss2_valid, iss1_wen, iss2_wen,
           iss1_rd, iss2_rd, iss1_pc, iss2_pc, instr1_rs1, instr1_rs2, instr2_rs1, instr2_rs2
  );

  modport slave (
    input  flush, in1_valid, in2_valid, in1_rs1, in1_rs2, in1_rd, in2_rs1, in2_rs2, in2_rd,
           in1_rs1_use, in1_rs2_use, in1_wen, in2_rs1_use, in2_rs2_use, in2_wen,
           in1_pc, in2_pc, iss_ready, write1, write2, rd1, rd2,
    output in1_accept, in2_accept, iss1_valid, iss2_valid, iss1_wen, iss2_wen,
           iss1_rd, iss2_rd, iss1_pc, iss2_pc, instr1_rs1, instr1_rs2, instr2_rs1, instr2_rs2
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Dual-issue in-order issue stage: busy-register scoreboard, intra-pair hazard check and
// an issue register that drives the register-file read addresses.
module issue_scoreboard (
  input logic               clk,
  input logic               rst_n,
  issue_scoreboard_if.slave bus
);
  logic [31:0] r_busy;
  logic [31:0] w_clr, w_set, w_busy_eff;
  logic        w_adv, w_haz1, w_haz2, w_pair, w_acc1, w_acc2;

  logic        r_iss1_valid, r_iss2_valid, r_iss1_wen, r_iss2_wen;
  logic [4:0]  r_iss1_rd, r_iss2_rd;
  logic [31:0] r_iss1_pc, r_iss2_pc;
  logic [4:0]  r_instr1_rs1, r_instr1_rs2, r_instr2_rs1, r_instr2_rs2;

  function automatic logic hazard(input logic [31:0] be,
                                  input logic [4:0] rs1, input logic u1,
                                  input logic [4:0] rs2, input logic u2,
                                  input logic [4:0] rd,  input logic wen);
    return (u1 & be[rs1]) | (u2 & be[rs2]) | (wen & be[rd]);
  endfunction

  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      w_clr[r] = (bus.write1 && bus.rd1 == 5'(r)) || (bus.write2 && bus.rd2 == 5'(r));
      w_set[r] = (w_acc1 && bus.in1_wen && bus.in1_rd == 5'(r)) ||
                 (w_acc2 && bus.in2_wen && bus.in2_rd == 5'(r));
    end
  end

  // Same-cycle writeback unblocks dependents.
  assign w_busy_eff = r_busy & ~w_clr;
  assign w_adv      = bus.iss_ready | ~(r_iss1_valid | r_iss2_valid);
  assign w_haz1     = hazard(w_busy_eff, bus.in1_rs1, bus.in1_rs1_use, bus.in1_rs2,
                             bus.in1_rs2_use, bus.in1_rd, bus.in1_wen);
  assign w_haz2     = hazard(w_busy_eff, bus.in2_rs1, bus.in2_rs1_use, bus.in2_rs2,
                             bus.in2_rs2_use, bus.in2_rd, bus.in2_wen);
  assign w_pair     = bus.in1_wen & (bus.in1_rd != 5'd0) &
                      ((bus.in2_rs1_use & (bus.in2_rs1 == bus.in1_rd)) |
                       (bus.in2_rs2_use & (bus.in2_rs2 == bus.in1_rd)) |
                       (bus.in2_wen     & (bus.in2_rd  == bus.in1_rd)));
  assign w_acc1     = rst_n & w_adv & ~bus.flush & bus.in1_valid & ~w_haz1;
  assign w_acc2     = w_acc1 & bus.in2_valid & ~w_haz2 & ~w_pair;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_busy <= '0;
    else if (bus.flush) r_busy <= '0;
    else                r_busy <= (r_busy & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.flush) begin
      r_iss1_valid <= 1'b0;   r_iss2_valid <= 1'b0;
      r_iss1_wen   <= 1'b0;   r_iss2_wen   <= 1'b0;
      r_iss1_rd    <= '0;     r_iss2_rd    <= '0;
      r_iss1_pc    <= '0;     r_iss2_pc    <= '0;
      r_instr1_rs1 <= '0;     r_instr1_rs2 <= '0;
      r_instr2_rs1 <= '0;     r_instr2_rs2 <= '0;
    end else if (w_adv) begin
      r_iss1_valid <= w_acc1;
      r_iss1_wen   <= w_acc1 & bus.in1_wen;
      r_iss1_rd    <= w_acc1 ? bus.in1_rd : 5'd0;
      r_iss1_pc    <= w_acc1 ? bus.in1_pc : 32'd0;
      r_instr1_rs1 <= (w_acc1 && bus.in1_rs1_use) ? bus.in1_rs1 : 5'd0;
      r_instr1_rs2 <= (w_acc1 && bus.in1_rs2_use) ? bus.in1_rs2 : 5'd0;
      r_iss2_valid <= w_acc2;
      r_iss2_wen   <= w_acc2 & bus.in2_wen;
      r_iss2_rd    <= w_acc2 ? bus.in2_rd : 5'd0;
      r_iss2_pc    <= w_acc2 ? bus.in2_pc : 32'd0;
      r_instr2_rs1 <= (w_acc2 && bus.in2_rs1_use) ? bus.in2_rs1 : 5'd0;
      r_instr2_rs2 <= (w_acc2 && bus.in2_rs2_use) ? bus.in2_rs2 : 5'd0;
    end
  end

  assign bus.in1_accept = w_acc1;
  assign bus.in2_accept = w_acc2;
  assign bus.iss1_valid = r_iss1_valid;
  assign bus.iss2_valid = r_iss2_valid;
  assign bus.iss1_wen   = r_iss1_wen;
  assign bus.iss2_wen   = r_iss2_wen;
  assign bus.iss1_rd    = r_iss1_rd;
  assign bus.iss2_rd    = r_iss2_rd;
  assign bus.iss1_pc    = r_iss1_pc;
  assign bus.iss2_pc    = r_iss2_pc;
  assign bus.instr1_rs1 = r_instr1_rs1;
  assign bus.instr1_rs2 = r_instr1_rs2;
  assign bus.instr2_rs1 = r_instr2_rs1;
  assign bus.instr2_rs2 = r_instr2_rs2;
endmodule
